// File: rtl/serial_adder_seq.sv
// Bit-serial WIDTH-bit adder: operands enter over a valid/ready handshake, one full-adder
// cell consumes one bit per clock (LSB first), and the result leaves over a second handshake.

module full_adder_with_enable (
  input  logic en_n,
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  // Active-low enable; the cell outputs are forced low while it is idle.
  assign s  = en_n ? 1'b0 : (a ^ b ^ ci);
  assign co = en_n ? 1'b0 : ((a & b) | (a & ci) | (b & ci));
endmodule

module serial_adder_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d;
  logic [WIDTH-1:0] sh_b_q, sh_b_d;
  logic [WIDTH-1:0] sh_s_q, sh_s_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;

  logic             fa_en_n, fa_s, fa_co;
  logic [WIDTH-1:0] sh_s_shift;

  full_adder_with_enable u_fa (
    .en_n (fa_en_n),
    .a    (sh_a_q[0]),
    .b    (sh_b_q[0]),
    .ci   (carry_q),
    .s    (fa_s),
    .co   (fa_co)
  );

  // Partial sum shifted right with the new bit at the MSB; written so that WIDTH=1 needs no special case.
  always_comb begin
    sh_s_shift            = sh_s_q >> 1;
    sh_s_shift[WIDTH-1]   = fa_s;
  end

  always_comb begin
    // NOTE: every signal gets a default first, so no path through this block can infer a latch.
    state_d = state_q;
    sh_a_d  = sh_a_q;
    sh_b_d  = sh_b_q;
    sh_s_d  = sh_s_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    fa_en_n = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sh_a_d  = op_a;
          sh_b_d  = op_b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        fa_en_n = 1'b0;
        sh_a_d  = sh_a_q >> 1;
        sh_b_d  = sh_b_q >> 1;
        sh_s_d  = sh_s_shift;
        carry_d = fa_co;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          sum_d   = sh_s_shift;
          cout_d  = fa_co;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sh_a_q  <= '0;
      sh_b_q  <= '0;
      sh_s_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_a_q  <= sh_a_d;
      sh_b_q  <= sh_b_d;
      sh_s_q  <= sh_s_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_serial_adder_seq.sv
// Self-checking bench for serial_adder_seq: an 8-bit instance driven by directed scenarios
// and a 1-bit instance running with both handshakes tied high; results go through a scoreboard.

module tb_serial_adder_seq;
  logic       clk = 1'b0;
  logic       rst_n, rst1_n;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // 8-bit instance
  logic       in_valid, in_ready, out_valid, out_ready, cin, cout, busy;
  logic [7:0] op_a, op_b, sum;

  serial_adder_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .cin(cin), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .busy(busy)
  );

  // 1-bit instance, handshakes tied high
  logic       in_ready1, out_valid1, cout1, busy1;
  logic [0:0] a1, b1, sum1;
  logic       c1;

  serial_adder_seq #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst1_n), .in_valid(1'b1), .in_ready(in_ready1),
    .op_a(a1), .op_b(b1), .cin(c1), .out_valid(out_valid1),
    .out_ready(1'b1), .sum(sum1), .cout(cout1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // ---------------- scoreboard / monitor, 8-bit ----------------
  logic [8:0] q8[$];
  int         acc_cyc8, busy_cnt8;
  logic       ov_prev8;

  always @(negedge rst_n) begin
    q8.delete();
    ov_prev8  = 1'b0;
    busy_cnt8 = 0;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) begin
        q8.push_back({1'b0, op_a} + {1'b0, op_b} + {8'd0, cin});
        acc_cyc8  = cyc;
        busy_cnt8 = 0;
      end
      if (busy) busy_cnt8++;
      if (out_valid && !ov_prev8) begin
        check("lat8", cyc - acc_cyc8, 9);
        check("busy8", busy_cnt8, 8);
      end
      ov_prev8 = out_valid;
      if (out_valid && out_ready) begin
        if (q8.size() == 0) check("sb8_empty", 1, 0);
        else begin
          logic [8:0] e;
          e = q8.pop_front();
          check("sum8", {23'd0, cout, sum}, {23'd0, e});
        end
      end
    end
  end

  // ---------------- scoreboard / monitor, 1-bit ----------------
  logic [1:0] q1[$];
  int         acc_cyc1, last_out1, n_out1;
  logic       ov_prev1;

  always @(negedge clk) begin
    if (rst1_n) begin
      if (in_ready1) begin
        q1.push_back({1'b0, a1} + {1'b0, b1} + {1'b0, c1});
        acc_cyc1 = cyc;
      end
      if (out_valid1 && !ov_prev1) check("lat1", cyc - acc_cyc1, 2);
      ov_prev1 = out_valid1;
      if (out_valid1) begin
        if (n_out1 > 0) check("period1", cyc - last_out1, 3);
        last_out1 = cyc;
        n_out1++;
        if (q1.size() == 0) check("sb1_empty", 1, 0);
        else begin
          logic [1:0] e;
          e = q1.pop_front();
          check("sum1", {30'd0, cout1, sum1}, {30'd0, e});
        end
      end
    end
  end

  // 1-bit operands: 1+1+1 first, random once the first result is out.
  initial begin
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    n_out1 = 0; ov_prev1 = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (n_out1 > 0) begin
        a1 = 1'($urandom_range(1)); b1 = 1'($urandom_range(1)); c1 = 1'($urandom_range(1));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic c);
    bit acc = 0;
    @(posedge clk); #1;
    op_a = a; op_b = b; cin = c; in_valid = 1'b1;
    for (int i = 0; i < 30 && !acc; i++) begin
      @(negedge clk);
      if (in_ready) acc = 1;
    end
    if (!acc) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk); #1;
      if (in_ready && !busy && !out_valid) done = 1;
    end
    if (!done) check("idle_timeout", 0, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0; rst1_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1;
    op_a = '0; op_b = '0; cin = 1'b0;
    ov_prev8 = 1'b0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    #4;
    rst_n = 1'b1; rst1_n = 1'b1;

    // Directed sums, including the full ripple and all-ones/all-zeros corners
    run_op(8'h5A, 8'h33, 1'b0); wait_idle();
    run_op(8'hFF, 8'h01, 1'b0); wait_idle();
    run_op(8'hFF, 8'hFF, 1'b1); wait_idle();
    run_op(8'h00, 8'h00, 1'b0); wait_idle();
    for (int i = 0; i < 4; i++) begin
      run_op(8'($urandom), 8'($urandom), 1'($urandom_range(1)));
      wait_idle();
    end

    // Backpressure in DONE while new operands are offered
    begin
      logic [8:0] held;
      bit seen = 0;
      held = {1'b0, 8'hC3} + {1'b0, 8'h3C} + 9'd1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      op_a = 8'hC3; op_b = 8'h3C; cin = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 30 && !seen; i++) begin
        @(posedge clk); #1;
        if (out_valid) seen = 1;
      end
      check("bp_reach_done", seen, 1);
      op_a = 8'h11; op_b = 8'h22; cin = 1'b0;
      for (int i = 0; i < 5; i++) begin
        @(posedge clk); #1;
        check("bp_hold_sum", {cout, sum}, held);
        check("bp_in_ready", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_release_valid", out_valid, 0);
      check("bp_release_ready", in_ready, 1);
      check("bp_release_busy", busy, 0);
      @(posedge clk); #1;
      check("bp_next_accept", busy, 1);
      in_valid = 1'b0;
      wait_idle();
    end

    // Reset in the middle of a run
    @(posedge clk); #1;
    op_a = 8'h5A; op_b = 8'h33; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("abort_running", busy, 1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_sum", sum, 0);
    check("abort_cout", cout, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_busy", busy, 0);
    #2 rst_n = 1'b1;
    run_op(8'h12, 8'h34, 1'b0); wait_idle();

    repeat (4) @(posedge clk);
    check("sb8_drained", q8.size(), 0);
    check("sb1_results", (n_out1 > 10) ? 1 : 0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "global timeout");
  end

endmodule
